// File: rtl/detector_jogada_if.sv
// Bus between the button detector and the game control unit.
// The multipla line exists only when DETECTOR_JOGADA_REJEITA_MULTIPLA_EN is defined.
interface detector_jogada_if;
    logic       habilita;
    logic [3:0] botoes;
    logic       fez_jogada;
    logic [3:0] jogada;
    logic [1:0] jogada_cod;
`ifdef DETECTOR_JOGADA_REJEITA_MULTIPLA_EN
    logic       multipla;
`endif
    logic [2:0] db_estado;

    modport master (
        output habilita, botoes,
        input  fez_jogada, jogada, jogada_cod,
`ifdef DETECTOR_JOGADA_REJEITA_MULTIPLA_EN
        input  multipla,
`endif
        input  db_estado
    );

    modport slave (
        input  habilita, botoes,
        output fez_jogada, jogada, jogada_cod,
`ifdef DETECTOR_JOGADA_REJEITA_MULTIPLA_EN
        output multipla,
`endif
        output db_estado
    );
endinterface

// File: rtl/detector_jogada.sv
// Debounced push-button move detector: one fez_jogada pulse per press/release cycle.
// Define DETECTOR_JOGADA_REJEITA_MULTIPLA_EN to reject multi-button presses (multipla pulse).
module detector_jogada #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic             clock,
    input  logic             reset,
    detector_jogada_if.slave bus
);
    localparam int            CW       = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [2:0] {
        ESPERA  = 3'd0,
        FILTRA  = 3'd1,
        PULSO   = 3'd2,
`ifdef DETECTOR_JOGADA_REJEITA_MULTIPLA_EN
        SOLTA   = 3'd3,
        REJEITA = 3'd4
`else
        SOLTA   = 3'd3
`endif
    } state_t;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [3:0]    r_sync1, r_bs;
    logic [3:0]    r_cand, w_cand_next;
    logic [3:0]    r_jogada, w_jogada_next;
    logic [1:0]    r_cod, w_cod_next;
    logic [3:0]    w_low_onehot;
    logic [1:0]    w_low_cod;

    // Lowest set bit of the candidate wins when several buttons are held.
    assign w_low_onehot = r_cand & (~r_cand + 4'd1);

    always_comb begin
        w_low_cod = 2'd0;
        case (w_low_onehot)
            4'b0010: w_low_cod = 2'd1;
            4'b0100: w_low_cod = 2'd2;
            4'b1000: w_low_cod = 2'd3;
            default: w_low_cod = 2'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= ESPERA;
            r_cnt    <= '0;
            r_sync1  <= 4'b0;
            r_bs     <= 4'b0;
            r_cand   <= 4'b0;
            r_jogada <= 4'b0;
            r_cod    <= 2'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_sync1  <= bus.botoes;
            r_bs     <= r_sync1;
            r_cand   <= w_cand_next;
            r_jogada <= w_jogada_next;
            r_cod    <= w_cod_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_cand_next   = r_cand;
        w_jogada_next = r_jogada;
        w_cod_next    = r_cod;
        case (r_state)
            ESPERA: begin
                w_cnt_next = '0;
                if (bus.habilita && (r_bs != 4'b0)) begin
                    w_cand_next  = r_bs;
                    w_state_next = FILTRA;
                end
            end
            FILTRA: begin
                if ((r_bs != r_cand) || !bus.habilita) begin
                    w_cnt_next   = '0;
                    w_state_next = ESPERA;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_next = '0;
`ifdef DETECTOR_JOGADA_REJEITA_MULTIPLA_EN
                    if (w_low_onehot != r_cand) begin
                        w_state_next = REJEITA;
                    end else begin
                        w_state_next  = PULSO;
                        w_jogada_next = w_low_onehot;
                        w_cod_next    = w_low_cod;
                    end
`else
                    w_state_next  = PULSO;
                    w_jogada_next = w_low_onehot;
                    w_cod_next    = w_low_cod;
`endif
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            PULSO: begin
                w_cnt_next   = '0;
                w_state_next = SOLTA;
            end
`ifdef DETECTOR_JOGADA_REJEITA_MULTIPLA_EN
            REJEITA: begin
                w_cnt_next   = '0;
                w_state_next = SOLTA;
            end
`endif
            SOLTA: begin
                // Release window restarts on any bounce back to a pressed level.
                if (r_bs != 4'b0) begin
                    w_cnt_next = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = ESPERA;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = ESPERA;
            end
        endcase
    end

    assign bus.fez_jogada = (r_state == PULSO);
    assign bus.jogada     = r_jogada;
    assign bus.jogada_cod = r_cod;
    assign bus.db_estado  = r_state;
`ifdef DETECTOR_JOGADA_REJEITA_MULTIPLA_EN
    assign bus.multipla   = (r_state == REJEITA);
`endif
endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada (DEBOUNCE_CICLOS=4): directed scenarios plus random stimulus,
// each cycle compared with a timestamp-based model; honours DETECTOR_JOGADA_REJEITA_MULTIPLA_EN.
module tb_detector_jogada;
    localparam int N = 4;
`ifdef DETECTOR_JOGADA_REJEITA_MULTIPLA_EN
    localparam bit MULTI_EN = 1'b1;
`else
    localparam bit MULTI_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    detector_jogada_if bus_if();
    detector_jogada #(.DEBOUNCE_CICLOS(N)) dut (.clock(clk), .reset(rst_n), .bus(bus_if));

    int total = 0, bad = 0;
    int cyc = 0, pulse_cnt = 0, last_pulse = -1, mult_cnt = 0;

    // Model: phase codes 0 wait, 1 filter, 2 pulse, 3 release, 4 reject.
    int         m_phase = 0, m_stamp = 0;
    logic [3:0] m_hist0 = 0, m_hist1 = 0, m_cand = 0, m_jog = 0;
    logic [1:0] m_cod = 0;

    function automatic int lowest(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return k;
        return 0;
    endfunction

    task automatic model_edge(input logic rn, input logic hab, input logic [3:0] raw);
        logic [3:0] bs;
        if (!rn) begin
            m_phase = 0; m_cand = 0; m_jog = 0; m_cod = 0; m_hist0 = 0; m_hist1 = 0;
        end else begin
            bs = m_hist1;
            case (m_phase)
                0: if (hab && bs != 0) begin m_cand = bs; m_stamp = cyc; m_phase = 1; end
                1: if (bs != m_cand || !hab) m_phase = 0;
                   else if (cyc - m_stamp == N) begin
                       if (MULTI_EN && $countones(m_cand) > 1) m_phase = 4;
                       else begin
                           m_cod = 2'(lowest(m_cand));
                           m_jog = 4'b0001 << lowest(m_cand);
                           m_phase = 2;
                       end
                   end
                2, 4: begin m_phase = 3; m_stamp = cyc; end
                default: if (bs != 0) m_stamp = cyc;
                         else if (cyc - m_stamp == N) m_phase = 0;
            endcase
            m_hist1 = m_hist0;
            m_hist0 = raw;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] observed();
        logic m;
`ifdef DETECTOR_JOGADA_REJEITA_MULTIPLA_EN
        m = bus_if.multipla;
`else
        m = 1'b0;
`endif
        return {bus_if.fez_jogada, bus_if.jogada, bus_if.jogada_cod, bus_if.db_estado, m};
    endfunction

    task automatic step(input logic rn, input logic hab, input logic [3:0] b);
        logic [10:0] exp_v, obs_v;
        rst_n = rn; bus_if.habilita = hab; bus_if.botoes = b;
        @(posedge clk);
        cyc++;
        model_edge(rn, hab, b);
        #1;
        obs_v = observed();
        exp_v = {m_phase == 2, m_jog, m_cod, 3'(m_phase), m_phase == 4};
        if (obs_v[10] === 1'b1) begin pulse_cnt++; last_pulse = cyc; end
        if (obs_v[0] === 1'b1) mult_cnt++;
        total++;
        assert (obs_v === exp_v) else begin
            bad++;
            $error("FAIL outputs@%0d observed=%h expected=%h", cyc, obs_v, exp_v);
        end
        $display("cyc=%0d rst=%b hab=%b bot=%b -> fez=%b jog=%b cod=%0d st=%0d",
                 cyc, rn, hab, b, obs_v[10], obs_v[9:6], obs_v[5:4], obs_v[3:1]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b1, 4'b0000);
    endtask

    initial begin
        int p;
        logic [3:0] rb;
        logic rh;
        rst_n = 1'b0; bus_if.habilita = 1'b0; bus_if.botoes = 4'b0;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'b1111);
        check("reset_outputs", int'(observed()), 0);

        // Single press held 20 cycles.
        pulse_cnt = 0;
        step(1'b1, 1'b1, 4'b0100); p = cyc;
        for (int k = 1; k < 20; k++) step(1'b1, 1'b1, 4'b0100);
        check("press_pulses", pulse_cnt, 1);
        check("press_latency", last_pulse - p, 6);
        check("press_jogada", int'(bus_if.jogada), 4);
        check("press_cod", int'(bus_if.jogada_cod), 2);
        idle(8);

        // Bouncing button never accepted.
        pulse_cnt = 0;
        for (int k = 0; k < 12; k++) step(1'b1, 1'b1, ((k / 2) % 2 == 0) ? 4'b0010 : 4'b0000);
        idle(8);
        check("bounce_pulses", pulse_cnt, 0);
        check("bounce_state", int'(bus_if.db_estado), 0);

        // Press, bouncy release, second press.
        pulse_cnt = 0;
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 4'b0001);
        step(1'b1, 1'b1, 4'b0000);
        step(1'b1, 1'b1, 4'b0001);
        idle(9);
        step(1'b1, 1'b1, 4'b1000); p = cyc;
        for (int k = 1; k < 10; k++) step(1'b1, 1'b1, 4'b1000);
        check("two_press_pulses", pulse_cnt, 2);
        check("second_latency", last_pulse - p, 6);
        check("second_jogada", int'(bus_if.jogada), 8);
        idle(8);

        // Button held before habilita rises.
        pulse_cnt = 0;
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 4'b0010);
        step(1'b1, 1'b1, 4'b0010); p = cyc;
        for (int k = 1; k < 10; k++) step(1'b1, 1'b1, 4'b0010);
        check("hab_pulses", pulse_cnt, 1);
        check("hab_latency", last_pulse - p, 4);
        idle(8);

        // Two buttons together.
        pulse_cnt = 0; mult_cnt = 0;
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 4'b0110);
        check("multi_jogada", int'(bus_if.jogada), 2);
        check("multi_cod", int'(bus_if.jogada_cod), 1);
        check("multi_pulses", pulse_cnt, MULTI_EN ? 0 : 1);
        check("multi_flag", mult_cnt, MULTI_EN ? 1 : 0);
        idle(8);

        // Reset during FILTRA, then a held button needs a fresh window.
        pulse_cnt = 0;
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 4'b0001);
        check("rst_filtra_outputs", int'(observed()), 0);
        step(1'b1, 1'b1, 4'b0001); p = cyc;
        for (int k = 1; k < 12; k++) step(1'b1, 1'b1, 4'b0001);
        check("rst_filtra_pulses", pulse_cnt, 1);
        check("rst_filtra_latency", last_pulse - p, 6);
        idle(8);

        // Reset during PULSO.
        pulse_cnt = 0;
        for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 4'b0100);
        check("pre_rst_pulso", int'(bus_if.fez_jogada), 1);
        step(1'b0, 1'b1, 4'b0100);
        check("rst_pulso_outputs", int'(observed()), 0);
        step(1'b1, 1'b1, 4'b0100); p = cyc;
        for (int k = 1; k < 12; k++) step(1'b1, 1'b1, 4'b0100);
        check("rst_pulso_pulses", pulse_cnt, 2);
        check("rst_pulso_latency", last_pulse - p, 6);
        idle(8);

        // Random traffic against the model.
        rb = 4'b0; rh = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0) rb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) rh = ~rh;
            step(($urandom_range(0, 99) != 0), rh, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
